// File: rtl/regwb_arbiter.sv
// regwb_arbiter: arbitrates the regfile write port between pipeline writeback (port 0, fixed
// priority) and mul/div (port 1). Starvation guard enabled by `REGWB_ARBITER_STARVE_EN.
//   state  | meaning
//   NORM   | strict port-0 priority
//   FORCE1 | port 1 granted, port 0 refused for exactly one cycle
module regwb_arbiter #(
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_valid,
  input  logic [4:0]        p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_ready,
  input  logic              p1_valid,
  input  logic [4:0]        p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_ready,
  output logic              wen,
  output logic [4:0]        wa,
  output logic [DATA_W-1:0] wd,
  output logic              wsrc
);

  logic              wen_q, wen_d;
  logic [4:0]        wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              wsrc_q, wsrc_d;
  logic              p0_xfer, p1_xfer;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("regwb_arbiter: STARVE_LIMIT must be in 1..15");
  end

`ifdef REGWB_ARBITER_STARVE_EN
  typedef enum logic {NORM = 1'b0, FORCE1 = 1'b1} state_t;

  localparam logic [3:0] CNT_TC = 4'(STARVE_LIMIT - 1);

  state_t     state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       p1_refused;

  assign p0_ready   = (state_q == NORM);
  assign p1_ready   = (state_q == FORCE1) | ~p0_valid;
  assign p1_refused = p1_valid & ~p1_ready;

  // Counter clears by default: on a port-1 grant, when idle, and on entry to FORCE1.
  always_comb begin
    state_d      = NORM;
    starve_cnt_d = '0;
    if (state_q == NORM && p1_refused) begin
      if (starve_cnt_q == CNT_TC) state_d = FORCE1;
      else starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= NORM;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign p0_ready = 1'b1;
  assign p1_ready = ~p0_valid;
`endif

  assign p0_xfer = p0_valid & p0_ready;
  assign p1_xfer = p1_valid & p1_ready & ~p0_xfer;

  // x0 writes are consumed but never raise wen.
  always_comb begin
    wen_d  = 1'b0;
    wa_d   = wa_q;
    wd_d   = wd_q;
    wsrc_d = wsrc_q;
    if (p0_xfer) begin
      wen_d  = (p0_addr != 5'd0);
      wa_d   = p0_addr;
      wd_d   = p0_data;
      wsrc_d = 1'b0;
    end else if (p1_xfer) begin
      wen_d  = (p1_addr != 5'd0);
      wa_d   = p1_addr;
      wd_d   = p1_data;
      wsrc_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wen_q  <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      wsrc_q <= 1'b0;
    end else begin
      wen_q  <= wen_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      wsrc_q <= wsrc_d;
    end
  end

  assign wen  = wen_q;
  assign wa   = wa_q;
  assign wd   = wd_q;
  assign wsrc = wsrc_q;

endmodule

// File: tb/tb_regwb_arbiter.sv
// Self-checking bench for regwb_arbiter: refusal-count reference model plus directed literals.
// Builds with or without `REGWB_ARBITER_STARVE_EN.
module tb_regwb_arbiter;
  localparam int DW    = 64;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          p0_valid = 1'b0, p1_valid = 1'b0;
  logic [4:0]    p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_data = '0, p1_data = '0;
  logic          p0_ready, p1_ready;
  logic          wen, wsrc;
  logic [4:0]    wa;
  logic [DW-1:0] wd;

  int total = 0;
  int bad   = 0;

  // reference model: expected registered outputs and consecutive port-1 refusals
  logic          e_wen = 1'b0, e_wsrc = 1'b0;
  logic [4:0]    e_wa = '0;
  logic [DW-1:0] e_wd = '0;
  int            m_wait = 0;

  regwb_arbiter #(.DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_data(p0_data), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_data(p1_data), .p1_ready(p1_ready),
    .wen(wen), .wa(wa), .wd(wd), .wsrc(wsrc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    e_wen = 1'b0; e_wa = '0; e_wd = '0; e_wsrc = 1'b0; m_wait = 0;
  endtask

  // One clock: check outputs/readies against the model, advance across the edge,
  // retire accepted requests. g = granted port or -1.
  task automatic step(output int g);
    bit r0, r1, t0, t1;
    #1;
`ifdef REGWB_ARBITER_STARVE_EN
    r0 = (m_wait < LIMIT);
    r1 = (m_wait >= LIMIT) || !p0_valid;
`else
    r0 = 1'b1;
    r1 = !p0_valid;
`endif
    chk("p0_ready", {63'd0, p0_ready}, {63'd0, r0});
    chk("p1_ready", {63'd0, p1_ready}, {63'd0, r1});
    chk("wen", {63'd0, wen}, {63'd0, e_wen});
    chk("wa", {59'd0, wa}, {59'd0, e_wa});
    chk("wd", wd, e_wd);
    chk("wsrc", {63'd0, wsrc}, {63'd0, e_wsrc});
    t0 = p0_valid && r0;
    t1 = p1_valid && r1 && !t0;
    @(posedge clk);
    if (t0) begin
      e_wen = (p0_addr != 0); e_wa = p0_addr; e_wd = p0_data; e_wsrc = 1'b0;
    end else if (t1) begin
      e_wen = (p1_addr != 0); e_wa = p1_addr; e_wd = p1_data; e_wsrc = 1'b1;
    end else begin
      e_wen = 1'b0;
    end
    if (p1_valid && !r1) m_wait++;
    else m_wait = 0;
    #1;
    if (t0) p0_valid = 1'b0;
    if (t1) p1_valid = 1'b0;
    g = t0 ? 0 : (t1 ? 1 : -1);
  endtask

  // Keep a port requesting: issue a fresh request whenever the previous one was accepted.
  task automatic want(input bit w0, input bit w1);
    if (w0 && !p0_valid) begin
      p0_valid = 1'b1; p0_addr = 5'(1 + $urandom_range(14)); p0_data = {$urandom, $urandom};
    end
    if (w1 && !p1_valid) begin
      p1_valid = 1'b1; p1_addr = 5'(16 + $urandom_range(15)); p1_data = {$urandom, $urandom};
    end
  endtask

  task automatic drain();
    int g;
    for (int i = 0; i < 20 && (p0_valid || p1_valid); i++) step(g);
    step(g);
    chk("drain_idle", {63'd0, p0_valid | p1_valid}, 64'd0);
  endtask

`ifdef REGWB_ARBITER_STARVE_EN
  int exp_sim[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int exp_clr[9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
  int exp_sim[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int exp_clr[9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
`endif

  initial begin
    int g;
    int pr0[4] = '{90, 50, 100, 20};
    int pr1[4] = '{90, 80, 100, 30};

    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      p0_valid = 1'($urandom); p0_addr = 5'($urandom); p0_data = {$urandom, $urandom};
      p1_valid = 1'($urandom); p1_addr = 5'($urandom); p1_data = {$urandom, $urandom};
    end
    #1;
    chk("rst_wen", {63'd0, wen}, 64'd0);
    chk("rst_wa", {59'd0, wa}, 64'd0);
    chk("rst_wd", wd, 64'd0);
    chk("rst_wsrc", {63'd0, wsrc}, 64'd0);
    chk("rst_p0_ready", {63'd0, p0_ready}, 64'd1);
    p0_valid = 1'b0; p1_valid = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(g);

    // single write on port 0
    p0_valid = 1'b1; p0_addr = 5'd5; p0_data = 64'hDEAD_BEEF;
    step(g);
    #1;
    chk("sw_wen", {63'd0, wen}, 64'd1);
    chk("sw_wa", {59'd0, wa}, 64'd5);
    chk("sw_wd", wd, 64'hDEAD_BEEF);
    chk("sw_wsrc", {63'd0, wsrc}, 64'd0);
    step(g);
    #1;
    chk("sw_wen_after", {63'd0, wen}, 64'd0);

    // x0 write on port 1
    p1_valid = 1'b1; p1_addr = 5'd0; p1_data = 64'h1234;
    #1;
    chk("x0_p1_ready", {63'd0, p1_ready}, 64'd1);
    step(g);
    #1;
    chk("x0_wen", {63'd0, wen}, 64'd0);
    chk("x0_wsrc", {63'd0, wsrc}, 64'd1);
    chk("x0_wd", wd, 64'h1234);
    drain();

    // both ports requesting continuously
    for (int i = 0; i < 10; i++) begin
      want(1'b1, 1'b1);
      step(g);
      chk($sformatf("sim_grant%0d", i), 64'(g), 64'(exp_sim[i]));
    end
    drain();

    // starvation counter restarts after a normal port-1 grant
    for (int i = 0; i < 9; i++) begin
      want(i != 3, 1'b1);
      step(g);
      chk($sformatf("clr_grant%0d", i), 64'(g), 64'(exp_clr[i]));
    end
    drain();

    // randomized phases, with an asynchronous reset in the middle
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 500; c++) begin
        if (!p0_valid && $urandom_range(99) < pr0[ph]) begin
          p0_valid = 1'b1; p0_addr = 5'($urandom); p0_data = {$urandom, $urandom};
        end
        if (!p1_valid && $urandom_range(99) < pr1[ph]) begin
          p1_valid = 1'b1; p1_addr = 5'($urandom); p1_data = {$urandom, $urandom};
        end
        step(g);
        if (ph == 1 && c == 250) begin
          reset = 1'b0;
          #1;
          chk("mid_rst_wen", {63'd0, wen}, 64'd0);
          chk("mid_rst_wa", {59'd0, wa}, 64'd0);
          chk("mid_rst_wd", wd, 64'd0);
          chk("mid_rst_wsrc", {63'd0, wsrc}, 64'd0);
          model_reset();
          @(negedge clk);
          @(negedge clk);
          reset = 1'b1;
        end
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
